result_serializer: RTL
======================

Name: result_serializer

Overview:
- Parallel-to-serial output stage; the transmit-side counterpart of the per-bit input shift-register wrapper around the compressor.
- Captures one W-bit compressor result word (dst bits packed into a vector, dst0 = bit 0) through a valid/ready handshake.
- Shifts the word out one bit per clock with frame-valid and last markers, so a wide result leaves the device on a single pin.
- Sits between the compressor outputs and the device output pad or bench monitor.

Parameters:
- W, 24, result word width in bits (minimum 2).
- MSB_FIRST, 0, bit order: 0 sends bit 0 first, 1 sends bit W-1 first.

Ports:
- clk  input  1  sole clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a word to send.
- in_ready  output  1  serializer can accept a word this cycle.
- in_data  input  W  parallel result word.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a frame bit this cycle.
- sout_last  output  1  final bit of the current frame.
- busy  output  1  frame in progress.

Behaviour:
- Reset (rst high at posedge): state IDLE, shift register 0, counter 0. Outputs: sout=0, sout_valid=0, sout_last=0, busy=0; in_ready=1 from the first cycle after reset.
- Reset mid-frame: the frame is dropped at once. No further bits are sent and the word is not resumed.
- States: IDLE and SHIFT. PAR is added only with the optional feature.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, load in_data, set counter=0 and move to SHIFT.
  - Latency: the first bit appears on sout, with sout_valid=1, in the cycle after acceptance.
- SHIFT:
  - One bit per cycle; sout_valid=1 for exactly W consecutive cycles; counter increments by 1 each cycle.
  - MSB_FIRST=0: sout = shreg[0], shreg shifts right. MSB_FIRST=1: sout = shreg[W-1], shreg shifts left.
  - sout_last=1 only when counter==W-1.
- Back-to-back frames:
  - in_ready is 1 in IDLE and in the SHIFT cycle where counter==W-1; it is 0 in every other SHIFT cycle.
  - A word accepted in the last-bit cycle starts its bit 0 in the very next cycle, giving a gapless stream with no idle cycle.
  - If no word is accepted then, the next state is IDLE with sout_valid=0.
- in_valid while in_ready=0: ignored and not captured. The upstream source must hold the word until accepted.
- busy = (state != IDLE). sout and sout_last are 0 whenever sout_valid=0.
- Counter width is clog2(W+1). The counter never wraps within a frame and is reloaded to 0 on every acceptance.

Optional Feature:
- Macro: RESULT_SERIALIZER_PARITY_EN.
- Defined:
  - After the W data bits, state PAR sends one extra bit: even parity, the XOR of the captured word.
  - sout_valid stays 1, so frames are W+1 cycles long.
  - sout_last moves from data bit W-1 to the parity bit.
  - in_ready is asserted in the PAR cycle instead of the counter==W-1 cycle.
  - Parity is computed from the captured word, not from the live in_data.
- Undefined: no PAR state; frames are exactly W bits, as described above.

Test Plan:
- Reset, idle: hold rst 3 cycles, then release with in_valid=0 -> sout_valid=0, busy=0, in_ready=1 every cycle.
- Single frame, W=24, MSB_FIRST=0: in_data=24'hA5C3F0, accepted at cycle T -> cycles T+1..T+24 give sout bits 0,0,0,0,1,1,1,1,1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. sout_last=1 only at T+24; busy=0 at T+25.
- Back-to-back: hold in_valid=1 with 24'h000001 then 24'h800000 -> 48 contiguous sout_valid cycles. sout=1 at stream bits 0 and 47 only; sout_last at cycles 24 and 48.
- Backpressure: pulse a new word (24'hFFFFFF) at counter=5 of a frame in progress -> not accepted, in_ready=0, current frame bits unchanged.
- Mid-frame reset: assert rst at counter=10 -> next cycle sout_valid=0, busy=0, in_ready=1. A new word is then sent complete from bit 0.
- Parity build, RESULT_SERIALIZER_PARITY_EN defined: 24'h000001 -> 25-cycle frame, parity bit 1 with sout_last. 24'hA5C3F0 -> parity bit 0.

Source files
------------

// File: rtl/result_serializer.sv
// result_serializer: parallel-to-serial output stage for the compressor result word.
// Accepts one W-bit word over a valid/ready handshake and shifts it out one bit per
// clock with frame-valid and last markers. Back-to-back words stream with no gap.
// Optional feature macro: RESULT_SERIALIZER_PARITY_EN appends an even-parity bit
// (XOR of the captured word) as an extra PAR cycle at the end of each frame.
module result_serializer #(
  parameter int unsigned W         = 24,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         sout,
  output logic         sout_valid,
  output logic         sout_last,
  output logic         busy
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] LastCnt = CW'(W - 1);

`ifdef RESULT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e        r_state;
  state_e        w_state_d;
  logic [W-1:0]  r_shreg;
  logic [W-1:0]  w_shreg_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_d;
`ifdef RESULT_SERIALIZER_PARITY_EN
  logic          r_par;
  logic          w_par_d;
`endif

  logic          w_last_data;
  logic          w_accept;
  logic          w_shift_bit;

  // Handshake: ready when idle or in the final cycle of the current frame.
  always_comb begin
    w_last_data = (r_state == StShift) && (r_cnt == LastCnt);
`ifdef RESULT_SERIALIZER_PARITY_EN
    in_ready    = (r_state == StIdle) || (r_state == StPar);
`else
    in_ready    = (r_state == StIdle) || w_last_data;
`endif
    w_accept    = in_valid && in_ready;
    w_shift_bit = MSB_FIRST ? r_shreg[W-1] : r_shreg[0];
  end

  // Next-state logic for FSM, shift register, counter and parity.
  always_comb begin
    w_state_d = r_state;
    w_shreg_d = r_shreg;
    w_cnt_d   = r_cnt;
`ifdef RESULT_SERIALIZER_PARITY_EN
    w_par_d   = r_par;
`endif
    unique case (r_state)
      StIdle: begin
        // Loads happen in the accept branch below.
      end
      StShift: begin
        w_shreg_d = MSB_FIRST ? {r_shreg[W-2:0], 1'b0} : {1'b0, r_shreg[W-1:1]};
        if (w_last_data) begin
`ifdef RESULT_SERIALIZER_PARITY_EN
          w_state_d = StPar;
`else
          w_state_d = StIdle;
`endif
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
        end
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      StPar: begin
        w_state_d = StIdle;
      end
`endif
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
    // Acceptance overrides: a word taken in the final cycle chains straight into SHIFT.
    if (w_accept) begin
      w_state_d = StShift;
      w_shreg_d = in_data;
      w_cnt_d   = '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      w_par_d   = ^in_data;
`endif
    end
  end

  // State registers with synchronous active-high reset; a reset drops any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_shreg <= '0;
      r_cnt   <= '0;
`ifdef RESULT_SERIALIZER_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_d;
      r_shreg <= w_shreg_d;
      r_cnt   <= w_cnt_d;
`ifdef RESULT_SERIALIZER_PARITY_EN
      r_par   <= w_par_d;
`endif
    end
  end

  // Serial outputs; data and last are forced low outside a frame.
  always_comb begin
    sout       = 1'b0;
    sout_last  = 1'b0;
    sout_valid = (r_state != StIdle);
    busy       = (r_state != StIdle);
    unique case (r_state)
      StShift: begin
        sout = w_shift_bit;
`ifndef RESULT_SERIALIZER_PARITY_EN
        sout_last = w_last_data;
`endif
      end
`ifdef RESULT_SERIALIZER_PARITY_EN
      StPar: begin
        sout      = r_par;
        sout_last = 1'b1;
      end
`endif
      default: begin
        sout      = 1'b0;
        sout_last = 1'b0;
      end
    endcase
  end

endmodule
